// File: rtl/acc_datapath.sv
// Accumulator datapath for a BIP-class processor: ACC register, operand sign
// extension, ACC/ALU source muxes and an add/subtract unit.

module acc_signext #(
    parameter int E_BITS = 16,
    parameter int D_BITS = 11
) (
    input  logic [D_BITS-1:0] data_i,
    output logic [E_BITS-1:0] ext_o
);
    generate
        if (E_BITS > D_BITS) begin : g_ext
            assign ext_o = {{(E_BITS-D_BITS){data_i[D_BITS-1]}}, data_i};
        end else begin : g_same
            assign ext_o = data_i;
        end
    endgenerate
endmodule

module acc_mux_b #(
    parameter int E_BITS = 16
) (
    input  logic              sel_i,
    input  logic [E_BITS-1:0] ram_i,
    input  logic [E_BITS-1:0] ext_i,
    output logic [E_BITS-1:0] b_o
);
    assign b_o = sel_i ? ext_i : ram_i;
endmodule

module acc_mux_a #(
    parameter int E_BITS = 16,
    parameter int S_BITS = 2
) (
    input  logic [S_BITS-1:0] sel_i,
    input  logic [E_BITS-1:0] ram_i,
    input  logic [E_BITS-1:0] ext_i,
    input  logic [E_BITS-1:0] res_i,
    input  logic [E_BITS-1:0] acc_i,
    output logic [E_BITS-1:0] a_o
);
    always_comb begin
        a_o = acc_i;
        // Any code outside LD/LDI/ALU selects the current ACC, so it never changes ACC.
        case (sel_i)
            S_BITS'(0): a_o = ram_i;
            S_BITS'(1): a_o = ext_i;
            S_BITS'(2): a_o = res_i;
            default:    a_o = acc_i;
        endcase
    end
endmodule

module acc_alu #(
    parameter int E_BITS = 16
) (
    input  logic              op_i,
    input  logic [E_BITS-1:0] a_i,
    input  logic [E_BITS-1:0] b_i,
    output logic [E_BITS-1:0] res_o
);
    // Modulo 2^E_BITS; carry out is intentionally discarded.
    assign res_o = op_i ? (a_i - b_i) : (a_i + b_i);
endmodule

module acc_reg #(
    parameter int E_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [E_BITS-1:0] d_i,
    output logic [E_BITS-1:0] q_o
);
    logic [E_BITS-1:0] acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    acc_q <= '0;
        else if (en_i) acc_q <= d_i;
    end

    assign q_o = acc_q;
endmodule

module acc_datapath #(
    parameter int E_BITS = 16,
    parameter int D_BITS = 11,
    parameter int S_BITS = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [D_BITS-1:0] i_Data,
    input  logic [E_BITS-1:0] i_Data_ram,
    input  logic [S_BITS-1:0] sel_A,
    input  logic              sel_B,
    input  logic              i_op,
    input  logic              w_acc,
    output logic [E_BITS-1:0] o_Data_ram,
    output logic [D_BITS-1:0] o_Addr_ram
);
    logic [E_BITS-1:0] ext;
    logic [E_BITS-1:0] mux_b;
    logic [E_BITS-1:0] res;
    logic [E_BITS-1:0] mux_a;
    logic [E_BITS-1:0] acc;

    acc_signext #(.E_BITS(E_BITS), .D_BITS(D_BITS)) u_ext (
        .data_i (i_Data),
        .ext_o  (ext)
    );

    acc_mux_b #(.E_BITS(E_BITS)) u_mux_b (
        .sel_i (sel_B),
        .ram_i (i_Data_ram),
        .ext_i (ext),
        .b_o   (mux_b)
    );

    acc_alu #(.E_BITS(E_BITS)) u_alu (
        .op_i  (i_op),
        .a_i   (acc),
        .b_i   (mux_b),
        .res_o (res)
    );

    acc_mux_a #(.E_BITS(E_BITS), .S_BITS(S_BITS)) u_mux_a (
        .sel_i (sel_A),
        .ram_i (i_Data_ram),
        .ext_i (ext),
        .res_i (res),
        .acc_i (acc),
        .a_o   (mux_a)
    );

    acc_reg #(.E_BITS(E_BITS)) u_acc (
        .clk   (i_clock),
        .rst_n (i_reset),
        .en_i  (w_acc),
        .d_i   (mux_a),
        .q_o   (acc)
    );

    assign o_Data_ram = acc;
    assign o_Addr_ram = i_Data;
endmodule

// File: tb/tb_acc_datapath.sv
// Directed bench for acc_datapath: reset, program sequence, gating, sign
// extension, wrap-around and mid-sequence reset with hand-computed values.

module tb_acc_datapath;
    localparam int E_BITS = 16;
    localparam int D_BITS = 11;
    localparam int S_BITS = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [D_BITS-1:0] data;
    logic [E_BITS-1:0] data_ram;
    logic [S_BITS-1:0] sel_a;
    logic              sel_b;
    logic              op;
    logic              w_acc;
    logic [E_BITS-1:0] dout;
    logic [D_BITS-1:0] addr;

    int checks = 0;
    int errors = 0;

    acc_datapath #(.E_BITS(E_BITS), .D_BITS(D_BITS), .S_BITS(S_BITS)) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_Data     (data),
        .i_Data_ram (data_ram),
        .sel_A      (sel_a),
        .sel_B      (sel_b),
        .i_op       (op),
        .w_acc      (w_acc),
        .o_Data_ram (dout),
        .o_Addr_ram (addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [E_BITS-1:0] obs, input logic [E_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, take one rising edge, sample 1 ns after it.
    task automatic step(input logic [S_BITS-1:0] sa, input logic sb, input logic o,
                        input logic [D_BITS-1:0] d, input logic w);
        sel_a = sa; sel_b = sb; op = o; data = d; w_acc = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; data = 11'h7FF; data_ram = 16'hABCD;
        sel_a = 2'b01; sel_b = 1'b1; op = 1'b0; w_acc = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_acc", dout, 16'h0000);
        data = 11'h002;
        #1;
        check("reset_addr", {5'b0, addr}, 16'h0002);
        @(posedge clk); #1;
        check("reset_overrides_w", dout, 16'h0000);
        rst_n = 1'b1;
        data_ram = 16'h0001;

        step(2'b00, 1'b0, 1'b0, 11'd2, 1'b1); check("LD", dout, 16'h0001);
        check("addr_LD", {5'b0, addr}, 16'h0002);
        step(2'b01, 1'b0, 1'b0, 11'd3, 1'b1); check("LDI", dout, 16'h0003);
        step(2'b10, 1'b0, 1'b0, 11'd0, 1'b1); check("ADD", dout, 16'h0004);
        step(2'b10, 1'b1, 1'b0, 11'd2, 1'b1); check("ADDI", dout, 16'h0006);
        step(2'b10, 1'b0, 1'b1, 11'd0, 1'b1); check("SUB", dout, 16'h0005);
        step(2'b10, 1'b1, 1'b1, 11'd1, 1'b1); check("SUBI", dout, 16'h0004);

        for (int i = 0; i < 3; i++) begin
            step(2'b10, 1'b1, 1'b0, 11'h005, 1'b0);
            check("gate_hold", dout, 16'h0004);
        end
        step(2'b10, 1'b1, 1'b0, 11'h005, 1'b1); check("gate_write", dout, 16'h0009);

        step(2'b01, 1'b0, 1'b0, 11'h7FF, 1'b1); check("sext_7FF", dout, 16'hFFFF);
        step(2'b01, 1'b0, 1'b0, 11'h400, 1'b1); check("sext_400", dout, 16'hFC00);
        step(2'b01, 1'b0, 1'b0, 11'h3FF, 1'b1); check("sext_3FF", dout, 16'h03FF);

        step(2'b01, 1'b0, 1'b0, 11'h7FF, 1'b1); check("wrap_load", dout, 16'hFFFF);
        step(2'b10, 1'b1, 1'b0, 11'h001, 1'b1); check("wrap_add", dout, 16'h0000);
        step(2'b10, 1'b0, 1'b1, 11'h000, 1'b1); check("wrap_sub", dout, 16'hFFFF);
        step(2'b11, 1'b0, 1'b0, 11'h123, 1'b1); check("selA11_hold", dout, 16'hFFFF);
        data_ram = 16'h5A5A;
        step(2'b11, 1'b1, 1'b1, 11'h001, 1'b1); check("selA11_hold2", dout, 16'hFFFF);
        data_ram = 16'h0001;

        step(2'b10, 1'b1, 1'b0, 11'd2, 1'b1); check("pre_rst_addi1", dout, 16'h0001);
        step(2'b10, 1'b1, 1'b0, 11'd2, 1'b1); check("pre_rst_addi2", dout, 16'h0003);
        rst_n = 1'b0;
        #2;
        check("mid_reset_async", dout, 16'h0000);
        check("mid_reset_addr", {5'b0, addr}, 16'h0002);
        #2 rst_n = 1'b1;
        #1;
        check("post_release_no_edge", dout, 16'h0000);
        @(posedge clk); #1;
        check("post_release_addi", dout, 16'h0002);
        step(2'b10, 1'b1, 1'b0, 11'd2, 1'b1); check("post_release_addi2", dout, 16'h0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_datapath.md
# acc_datapath

Accumulator datapath of the BIP-class processor. It holds the E_BITS accumulator (ACC) and sign-extends the D_BITS operand field of the current instruction. It selects the ACC source (RAM data, immediate or ALU result) and adds or subtracts the second operand. It sits between the control unit (select/enable/op signals), program memory (operand field) and data memory (address, write data, read data).

## Interface
Parameters:
- E_BITS, 16, data width: ACC, ALU and data-memory words.
- D_BITS, 11, operand/address field width. Requirement: E_BITS ≥ D_BITS.
- S_BITS, 2, width of the ACC-source select.

Ports:
- i_clock  in  1  single system clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset. Asserting it clears ACC immediately. Release is synchronous to i_clock.
- i_Data  in  D_BITS  operand field from program memory (ROM).
- i_Data_ram  in  E_BITS  read data from data memory (RAM).
- sel_A  in  S_BITS  ACC source select.
- sel_B  in  1  ALU second-operand select.
- i_op  in  1  ALU operation: 0 = add, 1 = subtract.
- w_acc  in  1  ACC write enable.
- o_Data_ram  out  E_BITS  RAM write data; always equals ACC.
- o_Addr_ram  out  D_BITS  RAM address; always equals i_Data (combinational pass-through).

## Operation
- Sign extension: EXT = i_Data sign-extended to E_BITS; bit D_BITS-1 is replicated into the upper bits.
- Mux B (ALU operand):
  - sel_B=0 → i_Data_ram
  - sel_B=1 → EXT
- ALU:
  - i_op=0 → RES = ACC + B
  - i_op=1 → RES = ACC − B
  - Two's complement, truncated to E_BITS (modulo 2^E_BITS).
  - No carry, overflow or flag outputs.
- Mux A (ACC next value):
  - sel_A=00 → i_Data_ram (LD)
  - sel_A=01 → EXT (LDI)
  - sel_A=10 → RES (ADD/ADDI/SUB/SUBI)
  - sel_A=11 → ACC (hold; reserved code, never changes ACC)
- ACC register:
  - On a rising edge with w_acc=1, ACC ← MuxA.
  - With w_acc=0, ACC holds regardless of sel_A, sel_B and i_op.
- STO: the control unit keeps w_acc=0. The RAM takes o_Data_ram (ACC) at o_Addr_ram (i_Data); the datapath holds no RAM write enable.
- Structure: separate sign-extender, two muxes, adder/subtractor and ACC register submodules under the top level. The top level is purely structural.

## Timing
- Reset:
  - While i_reset=0, ACC=0 and o_Data_ram=0, asynchronously.
  - o_Addr_ram tracks i_Data even during reset.
- Latency:
  - ACC and o_Data_ram update one rising edge after a qualifying w_acc=1.
  - o_Addr_ram, EXT, the muxes and the ALU are combinational (zero cycles).
- Control inputs and i_Data/i_Data_ram are sampled at the same rising edge that writes ACC. They must be stable around that edge.
- Read-modify-write: the ALU uses the pre-edge ACC value, so back-to-back w_acc=1 arithmetic cycles accumulate correctly, one operation per cycle.
- Reset asserted mid-sequence clears ACC at once and overrides w_acc. The first write after release occurs at the first rising edge with i_reset=1 and w_acc=1.
- Wrap-around:
  - 0xFFFF + 1 → 0x0000
  - 0x0000 − 1 → 0xFFFF
  - No saturation.

## Test plan
- Reset: i_reset=0 with arbitrary inputs → ACC=o_Data_ram=0x0000 without a clock edge. Change i_Data to 0x002 → o_Addr_ram=0x002 immediately.
- Program sequence, i_Data_ram=0x0001, one write per edge → ACC after each step:
  - LD 2 (sel_A=00): 0x0001
  - LDI 3 (sel_A=01): 0x0003
  - ADD (sel_A=10, sel_B=0, i_op=0): 0x0004
  - ADDI 2 (sel_B=1): 0x0006
  - SUB (sel_B=0, i_op=1): 0x0005
  - SUBI 1 (sel_B=1): 0x0004
  - o_Data_ram mirrors ACC throughout.
- Enable gating: ACC=0x0004, w_acc=0, sel_A=10, sel_B=1, i_Data=0x005 for 3 edges → ACC stays 0x0004. Then assert w_acc=1 for one edge → 0x0009.
- Sign extension: LDI with i_Data=0x7FF → 0xFFFF. LDI 0x400 → 0xFC00. LDI 0x3FF → 0x03FF.
- Wrap-around:
  - ACC=0xFFFF, ADDI 1 → 0x0000.
  - Then SUB with i_Data_ram=0x0001 → 0xFFFF.
  - sel_A=11 with w_acc=1 → ACC unchanged.
- Reset mid-operation: during an ADDI sequence, pulse i_reset low between edges → ACC=0 asynchronously. After release, ADDI 2 → 0x0002.
